// File: rtl/bw_clk_cl_rst_seq_if.sv
// Purpose : control/status bundle between the cluster clock/reset sequencer
//           and its requester (cken mask, warm-reset and debug-init pulses in;
//           per-cluster clock enables, global reset/debug-init and status out).
// Ports   : master = requester side (drives requests, observes outputs),
//           slave  = sequencer side (observes requests, drives outputs).
interface bw_clk_cl_rst_seq_if #(
  parameter int NUM_CL = 4
);

  logic [NUM_CL-1:0] cken_mask;     // per-cluster enable request, honoured in RUN
  logic              wrm_rst_req;   // warm-reset request pulse
  logic              dbg_init_req;  // debug-init request pulse
  logic [NUM_CL-1:0] cluster_cken;  // per-cluster clock enables
  logic              grst_l;        // global reset, active-low
  logic              gdbginit_l;    // global debug init, active-low
  logic              busy;          // sequencer not in RUN
  logic              seq_done;      // one-cycle pulse on each RUN entry

  modport master (
    output cken_mask,
    output wrm_rst_req,
    output dbg_init_req,
    input  cluster_cken,
    input  grst_l,
    input  gdbginit_l,
    input  busy,
    input  seq_done
  );

  modport slave (
    input  cken_mask,
    input  wrm_rst_req,
    input  dbg_init_req,
    output cluster_cken,
    output grst_l,
    output gdbginit_l,
    output busy,
    output seq_done
  );

endinterface

// File: rtl/bw_clk_cl_rst_seq.sv
// Purpose : cluster clock-enable / global reset sequencer. After reset the
//           cluster clock enables are turned on, grst_l/gdbginit_l are held low
//           for RST_CYC cycles, then the block runs; warm reset and debug init
//           can be requested from RUN.
// Ports   : gclk (clock), arst_l (async active-low reset), bus (slave modport
//           of bw_clk_cl_rst_seq_if carrying requests and all outputs).
// Latency : all outputs registered; requests act on the edge that samples them.
// Config  : define CLK_CL_STAGGER_EN to turn cluster enables on one at a time,
//           STAGGER_CYC cycles apart; otherwise all turn on together.
module bw_clk_cl_rst_seq #(
  parameter int NUM_CL      = 4,
  parameter int RST_CYC     = 16,
  parameter int DBG_CYC     = 8,
  parameter int STAGGER_CYC = 2
) (
  input  logic                  gclk,
  input  logic                  arst_l,
  bw_clk_cl_rst_seq_if.slave    bus
);

  // Cluster index must be able to hold NUM_CL ("all clusters enabled"),
  // and is never narrower than 2 bits.
  localparam int IDX_W = ($clog2(NUM_CL + 1) < 2) ? 2 : $clog2(NUM_CL + 1);

  localparam logic [7:0]       RST_LD   = 8'(RST_CYC - 1);
  localparam logic [7:0]       DBG_LD   = 8'(DBG_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CL);

  // Parameter legality checks at elaboration.
  if (RST_CYC < 1 || RST_CYC > 255) begin : g_bad_rst_cyc
    $error("RST_CYC must be in 1..255");
  end
  if (DBG_CYC < 1 || DBG_CYC > 255) begin : g_bad_dbg_cyc
    $error("DBG_CYC must be in 1..255");
  end
  if (STAGGER_CYC < 1 || STAGGER_CYC > 255) begin : g_bad_stagger_cyc
    $error("STAGGER_CYC must be in 1..255");
  end
  if (NUM_CL < 1) begin : g_bad_num_cl
    $error("NUM_CL must be at least 1");
  end

  typedef enum logic [2:0] {
    CKEN_ON  = 3'd0,
    RST_HOLD = 3'd1,
    RUN      = 3'd2,
    WRM_RST  = 3'd3,
    DBG_INIT = 3'd4
  } state_t;

  state_t            state_q,   state_nxt;
  logic [7:0]        cnt_q,     cnt_nxt;
  logic [IDX_W-1:0]  idx_q,     idx_nxt;
  logic [NUM_CL-1:0] cken_q,    cken_nxt;
  logic              grst_q,    grst_nxt;
  logic              gdbg_q,    gdbg_nxt;
  logic              busy_q,    busy_nxt;
  logic              done_q,    done_nxt;

  // State and output registers.
  always_ff @(posedge gclk or negedge arst_l) begin
    if (!arst_l) begin
      state_q <= CKEN_ON;
      cnt_q   <= '0;
      idx_q   <= '0;
      cken_q  <= '0;
      grst_q  <= 1'b0;
      gdbg_q  <= 1'b0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      idx_q   <= idx_nxt;
      cken_q  <= cken_nxt;
      grst_q  <= grst_nxt;
      gdbg_q  <= gdbg_nxt;
      busy_q  <= busy_nxt;
      done_q  <= done_nxt;
    end
  end

  // Next-state, counter and registered-output values.
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    idx_nxt   = idx_q;
    cken_nxt  = cken_q;

    case (state_q)
      CKEN_ON: begin
        // cnt_q counts the gap to the next enable; idx_q is the next
        // cluster to enable, IDX_LAST meaning every cluster is on.
        if (cnt_q != 8'd0) begin
          cnt_nxt = cnt_q - 8'd1;
        end else if (idx_q == IDX_LAST) begin
          state_nxt = RST_HOLD;
          cnt_nxt   = RST_LD;
        end else begin
`ifdef CLK_CL_STAGGER_EN
          cken_nxt = cken_q | (NUM_CL'(1) << idx_q);
          idx_nxt  = idx_q + IDX_W'(1);
          cnt_nxt  = 8'(STAGGER_CYC - 1);
`else
          cken_nxt = '1;
          idx_nxt  = IDX_LAST;
          cnt_nxt  = 8'd0;
`endif
        end
      end

      RST_HOLD, WRM_RST: begin
        // Requests are ignored while a reset hold is in progress.
        if (cnt_q == 8'd0) begin
          state_nxt = RUN;
        end else begin
          cnt_nxt = cnt_q - 8'd1;
        end
      end

      RUN: begin
        // Warm reset has priority; a simultaneous debug request is dropped.
        if (bus.wrm_rst_req) begin
          state_nxt = WRM_RST;
          cnt_nxt   = RST_LD;
        end else if (bus.dbg_init_req) begin
          state_nxt = DBG_INIT;
          cnt_nxt   = DBG_LD;
        end
      end

      DBG_INIT: begin
        // Warm reset preempts debug init and starts a full reset hold.
        if (bus.wrm_rst_req) begin
          state_nxt = WRM_RST;
          cnt_nxt   = RST_LD;
        end else if (cnt_q == 8'd0) begin
          state_nxt = RUN;
        end else begin
          cnt_nxt = cnt_q - 8'd1;
        end
      end

      default: begin
        state_nxt = CKEN_ON;
        cnt_nxt   = 8'd0;
        idx_nxt   = '0;
        cken_nxt  = '0;
      end
    endcase

    // RUN parks the counter at zero so every later entry starts clean.
    if (state_nxt == RUN) begin
      cnt_nxt = 8'd0;
    end

    // Cluster enables: forced on through reset holds, follow the mask when
    // the clusters are live, and built up bit by bit during CKEN_ON.
    if (state_nxt == RUN || state_nxt == DBG_INIT) begin
      cken_nxt = bus.cken_mask;
    end else if (state_nxt == RST_HOLD || state_nxt == WRM_RST) begin
      cken_nxt = '1;
    end

    grst_nxt = (state_nxt == RUN) || (state_nxt == DBG_INIT);
    gdbg_nxt = (state_nxt == RUN);
    busy_nxt = (state_nxt != RUN);
    done_nxt = (state_nxt == RUN) && (state_q != RUN);
  end

  assign bus.cluster_cken = cken_q;
  assign bus.grst_l       = grst_q;
  assign bus.gdbginit_l   = gdbg_q;
  assign bus.busy         = busy_q;
  assign bus.seq_done     = done_q;

endmodule
